bist_checker: RTL and testbench

Read-side response analyzer for the FIFO BIST. It monitors FIFO read data in the read clock domain and compares every word against a locally regenerated walking-ones sequence (seed 10'b0000000001, rotate left per word). It reports pass/fail, a saturating error count and the index of the first miscompare. It sits opposite the write-side pattern generator: that block produces the stimulus, this block judges what comes out of the FIFO.

---
 rtl/bist_pkg.sv | 16 +
 rtl/bist_checker_if.sv | 30 +++
 rtl/bist_aasd.sv | 23 ++
 rtl/bist_exp_gen.sv | 27 ++
 rtl/bist_checker.sv | 162 ++++++++++++++++
 tb/tb_bist_checker.sv | 217 +++++++++++++++++++++
 6 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the FIFO BIST pattern generator and response checker:
// controller states, the walking-ones seed and the rotate helper.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_t;

    localparam int BIST_SEED = 1;

    // Rotate the low w bits of v left by one; bits above w are cleared.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/bist_checker_if.sv
// Read-side bus of the BIST checker: FIFO read observation in, verdict out.
interface bist_checker_if #(
    parameter int WIDTH     = 10,
    parameter int NUM_WORDS = 20,
    parameter int ERR_W     = 8
);
    localparam int FW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic             START;
    logic             R_EN;
    logic             EMPTY;
    logic [WIDTH-1:0] DOUT;
    logic [WIDTH-1:0] EXP;
    logic [ERR_W-1:0] ERR_CNT;
    logic [FW-1:0]    FIRST_ERR;
    logic             BUSY;
    logic             DONE;
    logic             PASS;

    modport master (
        output START, R_EN, EMPTY, DOUT,
        input  EXP, ERR_CNT, FIRST_ERR, BUSY, DONE, PASS
    );

    modport slave (
        input  START, R_EN, EMPTY, DOUT,
        output EXP, ERR_CNT, FIRST_ERR, BUSY, DONE, PASS
    );

endinterface

// File: rtl/bist_aasd.sv
// Reset conditioner: asserts asynchronously, releases two clock edges after
// the external reset deasserts.
module bist_aasd (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_n = r_sync;

endmodule

// File: rtl/bist_exp_gen.sv
// Expected-pattern ring register: reseeds on load, rotates left on advance.
module bist_exp_gen
    import bist_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_adv,
    output logic [WIDTH-1:0] o_exp
);
    logic [WIDTH-1:0] r_exp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp <= WIDTH'(BIST_SEED);
        end else if (i_load) begin
            r_exp <= WIDTH'(BIST_SEED);
        end else if (i_adv) begin
            r_exp <= WIDTH'(rotl(64'(r_exp), WIDTH));
        end
    end

    assign o_exp = r_exp;

endmodule

// File: rtl/bist_checker.sv
// FIFO BIST response analyzer: compares each read word against the walking-ones
// sequence and reports pass/fail, a saturating error count and the first bad index.
module bist_checker
    import bist_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int NUM_WORDS = 20,
    parameter int ERR_W     = 8
) (
    input  logic          R_CLK,
    input  logic          R_RST,
    bist_checker_if.slave bus
);
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam int FW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic w_rst_n;

    bist_state_t      r_state, w_state_next;
    logic [CW-1:0]    r_issued, w_issued_next;
    logic [CW-1:0]    r_checked, w_checked_next;
    logic             r_rd_pend, w_rd_pend_next;
    logic             r_err_seen, w_err_seen_next;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_next;
    logic [FW-1:0]    r_first_err, w_first_err_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             r_pass, w_pass_next;

    logic             w_start_run;
    logic             w_acc;
    logic             w_unf;
    logic             w_mis;
    logic             w_adv;
    logic [1:0]       w_n_err;
    logic [ERR_W:0]   w_err_sum;
    logic [WIDTH-1:0] w_exp;

    bist_aasd u_aasd (
        .i_clk   (R_CLK),
        .i_rst_n (R_RST),
        .o_rst_n (w_rst_n)
    );

    bist_exp_gen #(.WIDTH(WIDTH)) u_exp_gen (
        .i_clk   (R_CLK),
        .i_rst_n (w_rst_n),
        .i_load  (w_start_run),
        .i_adv   (w_adv),
        .o_exp   (w_exp)
    );

    always_ff @(posedge R_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= IDLE;
            r_issued    <= '0;
            r_checked   <= '0;
            r_rd_pend   <= 1'b0;
            r_err_seen  <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_issued    <= w_issued_next;
            r_checked   <= w_checked_next;
            r_rd_pend   <= w_rd_pend_next;
            r_err_seen  <= w_err_seen_next;
            r_err_cnt   <= w_err_cnt_next;
            r_first_err <= w_first_err_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_issued_next    = r_issued;
        w_checked_next   = r_checked;
        w_rd_pend_next   = 1'b0;
        w_err_seen_next  = r_err_seen;
        w_err_cnt_next   = r_err_cnt;
        w_first_err_next = r_first_err;
        w_busy_next      = r_busy;
        w_done_next      = r_done;
        w_pass_next      = r_pass;
        w_start_run      = 1'b0;
        w_acc            = 1'b0;
        w_unf            = 1'b0;
        w_mis            = 1'b0;
        w_adv            = 1'b0;
        w_n_err          = 2'd0;
        w_err_sum        = '0;

        // The word read last cycle is on DOUT now; this can land in DRAIN too.
        if (r_rd_pend) begin
            w_adv          = 1'b1;
            w_mis          = (bus.DOUT != w_exp);
            w_checked_next = r_checked + CW'(1);
        end

        case (r_state)
            IDLE, DONE: begin
                if (bus.START) begin
                    w_start_run      = 1'b1;
                    w_state_next     = RUN;
                    w_issued_next    = '0;
                    w_checked_next   = '0;
                    w_err_seen_next  = 1'b0;
                    w_err_cnt_next   = '0;
                    w_first_err_next = '0;
                    w_busy_next      = 1'b1;
                    w_done_next      = 1'b0;
                    w_pass_next      = 1'b0;
                end
            end
            RUN: begin
                w_acc = bus.R_EN & ~bus.EMPTY;
                w_unf = bus.R_EN &  bus.EMPTY;
                if (w_acc) begin
                    w_issued_next  = r_issued + CW'(1);
                    w_rd_pend_next = 1'b1;
                end
                if (w_issued_next == CW'(NUM_WORDS)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_checked == CW'(NUM_WORDS)) begin
                    w_state_next = DONE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_pass_next  = (r_err_cnt == '0);
                end
            end
            default: w_state_next = IDLE;
        endcase

        // A miscompare belongs to an older word than a same-cycle underflow.
        w_n_err = {1'b0, w_mis} + {1'b0, w_unf};
        if (w_n_err != 2'd0) begin
            w_err_sum      = {1'b0, r_err_cnt} + (ERR_W+1)'(w_n_err);
            w_err_cnt_next = (w_err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : w_err_sum[ERR_W-1:0];
            if (!r_err_seen) begin
                w_err_seen_next  = 1'b1;
                w_first_err_next = w_mis ? FW'(r_checked) : FW'(r_issued);
            end
        end
    end

    assign bus.EXP       = w_exp;
    assign bus.ERR_CNT   = r_err_cnt;
    assign bus.FIRST_ERR = r_first_err;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.PASS      = r_pass;

endmodule

// File: tb/tb_bist_checker.sv
// Bench for bist_checker: randomized directed runs against a word-level model,
// with a second instance using a 2-bit error counter to observe saturation.
module tb_bist_checker;
    localparam int WIDTH = 10;
    localparam int N     = 20;
    localparam int MAXC  = 300;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ren   = 1'b0;
    logic       empty = 1'b0;
    logic [9:0] dout  = '0;

    always #5 clk = ~clk;

    bist_checker_if #(.WIDTH(WIDTH), .NUM_WORDS(N), .ERR_W(8)) bus_a ();
    bist_checker_if #(.WIDTH(WIDTH), .NUM_WORDS(N), .ERR_W(2)) bus_s ();

    assign bus_a.START = start;
    assign bus_a.R_EN  = ren;
    assign bus_a.EMPTY = empty;
    assign bus_a.DOUT  = dout;
    assign bus_s.START = start;
    assign bus_s.R_EN  = ren;
    assign bus_s.EMPTY = empty;
    assign bus_s.DOUT  = dout;

    bist_checker #(.WIDTH(WIDTH), .NUM_WORDS(N), .ERR_W(8)) dut_a (
        .R_CLK (clk),
        .R_RST (rst_n),
        .bus   (bus_a.slave)
    );

    bist_checker #(.WIDTH(WIDTH), .NUM_WORDS(N), .ERR_W(2)) dut_s (
        .R_CLK (clk),
        .R_RST (rst_n),
        .bus   (bus_s.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Word-level model: phase 0 idle, 1 issuing reads, 2 draining, 3 finished.
    int m_phase, m_issued, m_checked, m_err, m_first;
    bit m_seen, m_pend, m_busy, m_done, m_pass;

    function automatic logic [9:0] word(input int k);
        logic [9:0] w;
        w = 10'd1 << (k % WIDTH);
        return w;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, "/a.exp"},   32'(bus_a.EXP),       32'(word(m_checked)));
        check({ctx, "/s.exp"},   32'(bus_s.EXP),       32'(word(m_checked)));
        check({ctx, "/a.err"},   32'(bus_a.ERR_CNT),   sat(m_err, 255));
        check({ctx, "/s.err"},   32'(bus_s.ERR_CNT),   sat(m_err, 3));
        check({ctx, "/a.first"}, 32'(bus_a.FIRST_ERR), m_first);
        check({ctx, "/s.first"}, 32'(bus_s.FIRST_ERR), m_first);
        check({ctx, "/a.busy"},  32'(bus_a.BUSY),      32'(m_busy));
        check({ctx, "/a.done"},  32'(bus_a.DONE),      32'(m_done));
        check({ctx, "/a.pass"},  32'(bus_a.PASS),      32'(m_pass));
        check({ctx, "/s.done"},  32'(bus_s.DONE),      32'(m_done));
        check({ctx, "/s.pass"},  32'(bus_s.PASS),      32'(m_pass));
    endtask

    task automatic model_reset();
        m_phase = 0; m_issued = 0; m_checked = 0; m_err = 0; m_first = 0;
        m_seen = 0; m_pend = 0; m_busy = 0; m_done = 0; m_pass = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input bit e, input logic [9:0] d);
        int errs, cand, old_phase, old_checked;
        bit new_pend;
        old_phase = m_phase; old_checked = m_checked;
        errs = 0; cand = -1; new_pend = 0;
        if ((old_phase == 0 || old_phase == 3) && s) begin
            m_phase = 1; m_issued = 0; m_checked = 0; m_err = 0; m_first = 0;
            m_seen = 0; m_pend = 0; m_busy = 1; m_done = 0; m_pass = 0;
            return;
        end
        if (m_pend) begin
            if (d !== word(m_checked)) begin errs++; cand = m_checked; end
            m_checked++;
        end
        if (old_phase == 1 && r) begin
            if (e) begin
                errs++;
                if (cand < 0) cand = m_issued;
            end else begin
                m_issued++;
                new_pend = 1;
            end
        end
        m_pend = new_pend;
        if (errs > 0) begin
            m_err += errs;
            if (!m_seen) begin m_first = cand; m_seen = 1; end
        end
        if (old_phase == 1 && m_issued == N) begin
            m_phase = 2;
        end else if (old_phase == 2 && old_checked == N) begin
            m_phase = 3; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
        end
    endtask

    task automatic cycle(input string ctx, input bit s, input bit r, input bit e, input logic [9:0] d);
        start = s; ren = r; empty = e; dout = d;
        @(posedge clk);
        model_step(s, r, e, d);
        #1;
        check_all(ctx);
    endtask

    // corrupt: -1 none, -2 every word inverted, else that word index reads 0.
    task automatic run(input string name, input int corrupt, input int unf_at,
                       input bit gapped, input bit noise, input int stop_after);
        int cyc;
        bit unf_done, s, r, e;
        logic [9:0] d;
        cycle({name, "/start"}, 1'b1, 1'b0, 1'b0, 10'($urandom));
        cyc = 0; unf_done = 0;
        while (m_phase != 3 && cyc < MAXC) begin
            if (stop_after >= 0 && m_issued >= stop_after) break;
            s = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            r = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            e = 1'b0;
            if (m_phase != 1) begin
                r = 1'($urandom_range(0, 1));
                e = 1'($urandom_range(0, 1));
            end else if (r && unf_at >= 0 && !unf_done && m_issued == unf_at) begin
                e = 1'b1; unf_done = 1;
            end
            if (m_pend) begin
                d = word(m_checked);
                if (corrupt == -2) d = ~d;
                else if (corrupt == m_checked) d = 10'h000;
            end else begin
                d = 10'($urandom);
            end
            cycle(name, s, r, e, d);
            cyc++;
        end
        start = 0; ren = 0; empty = 0;
        if (stop_after < 0) check({name, "/done_in_budget"}, 32'(bus_a.DONE), 1);
        $display("run %-10s cycles=%0d err=%0d first=%0d pass=%0b exp=%03h",
                 name, cyc, bus_a.ERR_CNT, bus_a.FIRST_ERR, bus_a.PASS, bus_a.EXP);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        repeat (4) cycle("idle", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        release_reset();

        run("clean", -1, -1, 1'b0, 1'b0, -1);
        check("clean/pass", 32'(bus_a.PASS), 1);
        check("clean/exp", 32'(bus_a.EXP), 32'h001);

        run("corrupt7", 7, -1, 1'b0, 1'b0, -1);
        check("corrupt7/err", 32'(bus_a.ERR_CNT), 1);
        check("corrupt7/first", 32'(bus_a.FIRST_ERR), 7);
        check("corrupt7/pass", 32'(bus_a.PASS), 0);

        run("underflow", -1, 3, 1'b0, 1'b0, -1);
        check("underflow/err", 32'(bus_a.ERR_CNT), 1);
        check("underflow/first", 32'(bus_a.FIRST_ERR), 3);

        run("allwrong", -2, -1, 1'b0, 1'b0, -1);
        check("allwrong/s.err", 32'(bus_s.ERR_CNT), 3);
        check("allwrong/a.err", 32'(bus_a.ERR_CNT), 20);
        check("allwrong/first", 32'(bus_s.FIRST_ERR), 0);

        run("dual", 4, 5, 1'b0, 1'b0, -1);
        check("dual/err", 32'(bus_a.ERR_CNT), 2);
        check("dual/first", 32'(bus_a.FIRST_ERR), 4);

        run("midreset", -1, -1, 1'b0, 1'b0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        release_reset();
        run("afterrst", -1, -1, 1'b0, 1'b0, -1);
        check("afterrst/pass", 32'(bus_a.PASS), 1);

        run("gapped", -1, -1, 1'b1, 1'b1, -1);
        check("gapped/pass", 32'(bus_a.PASS), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
